// File: rtl/key_click_decoder_pkg.sv
// Shared definitions for the key click decoder slice.
// Holds the event codes seen by the LED/mode logic, the FSM state encodings,
// and a helper that converts the window length in ms to clock cycles.
package key_click_decoder_pkg;

    typedef logic [1:0] evt_code_t;

    localparam evt_code_t EVT_NONE   = 2'd0;
    localparam evt_code_t EVT_SINGLE = 2'd1;
    localparam evt_code_t EVT_DOUBLE = 2'd2;
    localparam evt_code_t EVT_TRIPLE = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COUNT   = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    function automatic int unsigned win_cycles(input int unsigned clk_freq,
                                               input int unsigned win_ms);
        return (clk_freq / 1000) * win_ms;
    endfunction

endpackage

// File: rtl/key_click_decoder_if.sv
// Handshake bundle between the key debouncer / consumer and the click decoder.
//   key_ok    : debounced press pulse (source -> decoder)
//   evt_valid : one-cycle event strobe (decoder -> consumer)
//   evt_code  : click code, 0 unless evt_valid is high
//   busy      : decoder is counting clicks or in holdoff
// master = the side that drives key_ok and consumes events, slave = the decoder.
interface key_click_decoder_if;
    import key_click_decoder_pkg::*;

    logic      key_ok;
    logic      evt_valid;
    evt_code_t evt_code;
    logic      busy;

    modport master (output key_ok, input evt_valid, evt_code, busy);
    modport slave  (input key_ok, output evt_valid, evt_code, busy);

endinterface

// File: rtl/key_win_timer.sv
// Inter-click window timer.
//   clk, rst : clock and synchronous active-high reset
//   clr      : force the count back to zero (has priority over en)
//   en       : advance the count by one per cycle
//   done     : high while en=1 and the count sits at WIN_CNT-1
// The count saturates at WIN_CNT-1 instead of wrapping.
module key_win_timer #(
    parameter int unsigned WIN_CNT = 15_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int unsigned TW = (WIN_CNT > 2) ? $clog2(WIN_CNT) : 1;
    localparam logic [TW-1:0] LAST = TW'(WIN_CNT - 1);

    logic [TW-1:0] r_timer;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_timer <= '0;
        end else if (en && (r_timer != LAST)) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign done = en && (r_timer == LAST);

endmodule

// File: rtl/key_click_decoder.sv
// Groups debounced key presses falling inside a rolling window into
// single / double / triple click events.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of key_click_decoder_if
//              (key_ok in; evt_valid, evt_code, busy out, all registered)
// Parameters: CLK_FREQ (Hz), WIN_MS (window in ms), MAX_CLICK (2..3, count
// that emits at once and then blocks further clicks for one window).
module key_click_decoder
    import key_click_decoder_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned WIN_MS    = 300,
    parameter int unsigned MAX_CLICK = 3
) (
    input  logic              clk,
    input  logic              rst,
    key_click_decoder_if.slave bus
);

    localparam int unsigned WIN_CNT  = win_cycles(CLK_FREQ, WIN_MS);
    localparam evt_code_t   MAX_CODE = 2'(MAX_CLICK);

    logic [1:0] r_state;
    logic [1:0] r_cnt;
    logic       r_evt_valid;
    evt_code_t  r_evt_code;
    logic       r_busy;

    logic [1:0] w_state_nxt;
    logic [1:0] w_cnt_nxt;
    logic       w_evt_valid_nxt;
    evt_code_t  w_evt_code_nxt;
    logic       w_timer_clr;
    logic       w_timer_en;
    logic       w_timer_done;

    // Every accepted (or, in holdoff, ignored) press restarts the window;
    // holding the timer cleared in IDLE means COUNT always starts from zero.
    assign w_timer_clr = bus.key_ok || (r_state == ST_IDLE);
    assign w_timer_en  = (r_state != ST_IDLE);

    key_win_timer #(
        .WIN_CNT (WIN_CNT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_timer_clr),
        .en   (w_timer_en),
        .done (w_timer_done)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_evt_valid_nxt = 1'b0;
        w_evt_code_nxt  = EVT_NONE;
        case (r_state)
            ST_IDLE: begin
                if (bus.key_ok) begin
                    w_state_nxt = ST_COUNT;
                    w_cnt_nxt   = 2'd1;
                end
            end
            ST_COUNT: begin
                // key_ok is tested before expiry so a press on the last
                // window cycle is counted rather than closing the group.
                if (bus.key_ok) begin
                    if ((r_cnt + 2'd1) == MAX_CODE) begin
                        w_evt_valid_nxt = 1'b1;
                        w_evt_code_nxt  = MAX_CODE;
                        w_state_nxt     = ST_HOLDOFF;
                        w_cnt_nxt       = MAX_CODE;
                    end else if (r_cnt != MAX_CODE) begin
                        w_cnt_nxt = r_cnt + 2'd1;
                    end
                end else if (w_timer_done) begin
                    w_evt_valid_nxt = 1'b1;
                    w_evt_code_nxt  = r_cnt;
                    w_state_nxt     = ST_IDLE;
                    w_cnt_nxt       = 2'd0;
                end
            end
            ST_HOLDOFF: begin
                if (w_timer_done && !bus.key_ok) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 2'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 2'd0;
            r_evt_valid <= 1'b0;
            r_evt_code  <= EVT_NONE;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_evt_valid <= w_evt_valid_nxt;
            r_evt_code  <= w_evt_code_nxt;
            // Decoded from the next state so busy drops together with IDLE entry.
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.evt_valid = r_evt_valid;
    assign bus.evt_code  = r_evt_code;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_key_click_decoder.sv
// Testbench for key_click_decoder with a 1000-cycle window.
// Expected traces come from a click-grouping model working on the list of
// press times (gap <= WIN joins a group, MAX_CLICK presses emit at once and
// start a holdoff that every further press extends).
module tb_key_click_decoder;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned WIN_MS   = 1;
    localparam int          WIN      = 1000;
    localparam int          MAXC     = 3;
    localparam int          NCYC     = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    key_click_decoder_if kif ();

    key_click_decoder #(
        .CLK_FREQ  (CLK_FREQ),
        .WIN_MS    (WIN_MS),
        .MAX_CLICK (MAXC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (kif)
    );

    int tests = 0;
    int fails = 0;

    bit         pulse_map [NCYC];
    bit         rst_map   [NCYC];
    logic       obs_v     [NCYC];
    logic [1:0] obs_c     [NCYC];
    logic       obs_b     [NCYC];
    bit         exp_v     [NCYC];
    bit   [1:0] exp_c     [NCYC];
    bit         exp_b     [NCYC];

    task automatic clear_maps();
        for (int i = 0; i < NCYC; i++) begin
            pulse_map[i] = 1'b0;
            rst_map[i]   = 1'b0;
            exp_v[i]     = 1'b0;
            exp_c[i]     = 2'd0;
            exp_b[i]     = 1'b0;
        end
    endtask

    task automatic do_reset();
        kif.key_ok = 1'b0;
        rst        = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Cycle c: inputs driven just after edge c, outputs sampled at the
    // following negedge (so they reflect inputs of cycle c-1 and earlier).
    task automatic run_trace(input int len);
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            kif.key_ok = pulse_map[c];
            rst        = rst_map[c];
            @(negedge clk);
            obs_v[c] = kif.evt_valid;
            obs_c[c] = kif.evt_code;
            obs_b[c] = kif.busy;
        end
        @(posedge clk);
        #1;
        kif.key_ok = 1'b0;
        rst        = 1'b0;
    endtask

    // Presses in cycles [a,b]; expectations written only below cycle lim.
    function automatic void model_seg(input int a, input int b, input int lim);
        int q[$];
        int i, start, last, n, ev, end_busy;
        for (int c = a; c <= b; c++) if (pulse_map[c]) q.push_back(c);
        i = 0;
        while (i < q.size()) begin
            start = q[i];
            last  = start;
            n     = 1;
            i++;
            while (i < q.size() && n < MAXC && (q[i] - last) <= WIN) begin
                last = q[i];
                n++;
                i++;
            end
            if (n == MAXC) begin
                ev = last + 1;
                while (i < q.size() && (q[i] - last) <= WIN) begin
                    last = q[i];
                    i++;
                end
                end_busy = last + WIN + 1;
            end else begin
                ev       = last + WIN + 1;
                end_busy = ev;
            end
            for (int c = start + 1; c < end_busy && c < lim; c++) exp_b[c] = 1'b1;
            if (ev < lim) begin
                exp_v[ev] = 1'b1;
                exp_c[ev] = 2'(n);
            end
        end
    endfunction

    function automatic void model(input int len);
        int rc = -1;
        for (int c = 0; c < len; c++) if (rst_map[c]) rc = c;
        if (rc < 0) begin
            model_seg(0, len - 1, len);
        end else begin
            model_seg(0, rc - 1, rc + 1);
            model_seg(rc + 1, len - 1, len);
        end
    endfunction

    task automatic test_reset();
        int bad = -1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            kif.key_ok = (i % 2 == 0) ? 1'b1 : 1'(($urandom % 2));
            @(posedge clk);
            @(negedge clk);
            tests++;
            if (kif.evt_valid !== 1'b0 || kif.evt_code !== 2'd0 || kif.busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold cycle %0d: valid/code/busy got %b/%0d/%b want 0/0/0",
                         i, kif.evt_valid, kif.evt_code, kif.busy);
            end
        end
        rst        = 1'b0;
        kif.key_ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bad < 0 && (kif.evt_valid !== 1'b0 || kif.evt_code !== 2'd0 || kif.busy !== 1'b0))
                bad = i;
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL reset_after cycle %0d: outputs nonzero after reset, want 0/0/0", bad);
        end
    endtask

    task automatic test_single();
        int bad = -1, nev = 0;
        do_reset();
        clear_maps();
        pulse_map[10] = 1'b1;
        model(1100);
        run_trace(1100);
        for (int c = 0; c < 1100; c++) begin
            if (bad < 0 && (obs_v[c] !== exp_v[c] || obs_c[c] !== exp_c[c] || obs_b[c] !== exp_b[c])) bad = c;
            if (obs_v[c] === 1'b1) nev++;
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL single_trace cycle %0d: got %b/%0d/%b want %b/%0d/%b", bad,
                     obs_v[bad], obs_c[bad], obs_b[bad], exp_v[bad], exp_c[bad], exp_b[bad]);
        end
        tests++;
        if (obs_v[1011] !== 1'b1 || obs_c[1011] !== 2'd1) begin
            fails++;
            $display("FAIL single_event: cycle 1011 valid/code %b/%0d want 1/1", obs_v[1011], obs_c[1011]);
        end
        tests++;
        if (obs_b[1010] !== 1'b1 || obs_b[1011] !== 1'b0) begin
            fails++;
            $display("FAIL single_busy: busy@1010/1011 %b/%b want 1/0", obs_b[1010], obs_b[1011]);
        end
        tests++;
        if (nev != 1) begin
            fails++;
            $display("FAIL single_count: %0d events want 1", nev);
        end
    endtask

    task automatic test_double();
        int bad = -1, nmid = 0;
        do_reset();
        clear_maps();
        pulse_map[10]  = 1'b1;
        pulse_map[500] = 1'b1;
        model(1600);
        run_trace(1600);
        for (int c = 0; c < 1600; c++) begin
            if (bad < 0 && (obs_v[c] !== exp_v[c] || obs_c[c] !== exp_c[c] || obs_b[c] !== exp_b[c])) bad = c;
            if (c <= 1500 && obs_v[c] !== 1'b0) nmid++;
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL double_trace cycle %0d: got %b/%0d/%b want %b/%0d/%b", bad,
                     obs_v[bad], obs_c[bad], obs_b[bad], exp_v[bad], exp_c[bad], exp_b[bad]);
        end
        tests++;
        if (obs_v[1501] !== 1'b1 || obs_c[1501] !== 2'd2) begin
            fails++;
            $display("FAIL double_event: cycle 1501 valid/code %b/%0d want 1/2", obs_v[1501], obs_c[1501]);
        end
        tests++;
        if (nmid != 0) begin
            fails++;
            $display("FAIL double_early: %0d strobes before cycle 1501 want 0", nmid);
        end
    endtask

    task automatic test_triple_holdoff();
        int bad = -1, nev = 0;
        do_reset();
        clear_maps();
        pulse_map[10]   = 1'b1;
        pulse_map[300]  = 1'b1;
        pulse_map[600]  = 1'b1;
        pulse_map[900]  = 1'b1;
        pulse_map[2000] = 1'b1;
        model(3100);
        run_trace(3100);
        for (int c = 0; c < 3100; c++) begin
            if (bad < 0 && (obs_v[c] !== exp_v[c] || obs_c[c] !== exp_c[c] || obs_b[c] !== exp_b[c])) bad = c;
            if (obs_v[c] === 1'b1) nev++;
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL triple_trace cycle %0d: got %b/%0d/%b want %b/%0d/%b", bad,
                     obs_v[bad], obs_c[bad], obs_b[bad], exp_v[bad], exp_c[bad], exp_b[bad]);
        end
        tests++;
        if (obs_v[601] !== 1'b1 || obs_c[601] !== 2'd3) begin
            fails++;
            $display("FAIL triple_event: cycle 601 valid/code %b/%0d want 1/3", obs_v[601], obs_c[601]);
        end
        tests++;
        if (obs_b[1900] !== 1'b1 || obs_b[1901] !== 1'b0) begin
            fails++;
            $display("FAIL holdoff_busy: busy@1900/1901 %b/%b want 1/0", obs_b[1900], obs_b[1901]);
        end
        tests++;
        if (nev != 2 || obs_v[3001] !== 1'b1 || obs_c[3001] !== 2'd1) begin
            fails++;
            $display("FAIL holdoff_fresh: %0d events, cycle 3001 valid/code %b/%0d want 2 events, 1/1",
                     nev, obs_v[3001], obs_c[3001]);
        end
    endtask

    task automatic test_boundary();
        int bad = -1;
        do_reset();
        clear_maps();
        pulse_map[10]   = 1'b1;
        pulse_map[1010] = 1'b1;
        pulse_map[3000] = 1'b1;
        pulse_map[4002] = 1'b1;
        pulse_map[5003] = 1'b1;
        model(6200);
        run_trace(6200);
        for (int c = 0; c < 6200; c++)
            if (bad < 0 && (obs_v[c] !== exp_v[c] || obs_c[c] !== exp_c[c] || obs_b[c] !== exp_b[c])) bad = c;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL boundary_trace cycle %0d: got %b/%0d/%b want %b/%0d/%b", bad,
                     obs_v[bad], obs_c[bad], obs_b[bad], exp_v[bad], exp_c[bad], exp_b[bad]);
        end
        tests++;
        if (obs_v[1011] !== 1'b0 || obs_v[2011] !== 1'b1 || obs_c[2011] !== 2'd2) begin
            fails++;
            $display("FAIL expiry_click: valid@1011 %b, valid/code@2011 %b/%0d want 0, 1/2",
                     obs_v[1011], obs_v[2011], obs_c[2011]);
        end
        tests++;
        if (obs_v[5003] !== 1'b1 || obs_c[5003] !== 2'd1 || obs_v[6004] !== 1'b1 || obs_c[6004] !== 2'd1) begin
            fails++;
            $display("FAIL after_strobe: valid/code@5003 %b/%0d @6004 %b/%0d want 1/1 1/1",
                     obs_v[5003], obs_c[5003], obs_v[6004], obs_c[6004]);
        end
    endtask

    task automatic test_reset_mid();
        int bad = -1, nev = 0;
        do_reset();
        clear_maps();
        pulse_map[10]  = 1'b1;
        rst_map[400]   = 1'b1;
        pulse_map[500] = 1'b1;
        model(1700);
        run_trace(1700);
        for (int c = 0; c < 1700; c++) begin
            if (bad < 0 && (obs_v[c] !== exp_v[c] || obs_c[c] !== exp_c[c] || obs_b[c] !== exp_b[c])) bad = c;
            if (obs_v[c] === 1'b1) nev++;
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL rstmid_trace cycle %0d: got %b/%0d/%b want %b/%0d/%b", bad,
                     obs_v[bad], obs_c[bad], obs_b[bad], exp_v[bad], exp_c[bad], exp_b[bad]);
        end
        tests++;
        if (nev != 1 || obs_v[1501] !== 1'b1 || obs_c[1501] !== 2'd1 || obs_b[401] !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_event: %0d events, valid/code@1501 %b/%0d, busy@401 %b want 1, 1/1, 0",
                     nev, obs_v[1501], obs_c[1501], obs_b[401]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            int bad = -1;
            int t, gap, pick;
            do_reset();
            clear_maps();
            t = 10 + int'($urandom_range(0, 50));
            while (t < 6000 - 1200) begin
                pulse_map[t] = 1'b1;
                pick = int'($urandom_range(0, 9));
                case (pick)
                    0:       gap = WIN;
                    1:       gap = WIN + 1;
                    2:       gap = 1;
                    3:       gap = WIN - 1;
                    default: gap = int'($urandom_range(2, 1300));
                endcase
                t += gap;
            end
            model(6000);
            run_trace(6000);
            for (int c = 0; c < 6000; c++)
                if (bad < 0 && (obs_v[c] !== exp_v[c] || obs_c[c] !== exp_c[c] || obs_b[c] !== exp_b[c])) bad = c;
            tests++;
            if (bad >= 0) begin
                fails++;
                $display("FAIL random_%0d cycle %0d: got %b/%0d/%b want %b/%0d/%b", r, bad,
                         obs_v[bad], obs_c[bad], obs_b[bad], exp_v[bad], exp_c[bad], exp_b[bad]);
            end
        end
    endtask

    initial begin
        kif.key_ok = 1'b0;
        test_reset();
        test_single();
        test_double();
        test_triple_holdoff();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

endmodule
